// File: rtl/instr_fetch.sv
// instr_fetch: presents a small program store to a pipeline one entry at a time.
// Each entry is held on `next` for HOLD non-stalled cycles. A run is framed by
// HOLD cycles of NOP (zero) before it (PRIME) and HOLD cycles of NOP after it
// (DRAIN). A single-cycle `done` pulse follows DRAIN.
//
// Optional feature: define FETCH_LOOP_EN to make ISSUE loop from the last
// entry back to entry 0. In that build a `start` seen in ISSUE requests a stop,
// and the run drains at the next program-end boundary.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (program store is not reset)
//   load_en    program store write strobe, accepted in any state
//   load_addr  program store write address
//   load_data  program store write data
//   len        program length in entries, sampled on an accepted start; clipped to DEPTH
//   start      begin-issue pulse; ignored while a run is in progress
//   stall      freezes state, pc, hold counter and next while a run is active
//   next       instruction presented downstream (registered)
//   pc         index of the entry currently presented (0 outside ISSUE)
//   busy       high in PRIME and ISSUE
//   done       one-cycle pulse after DRAIN completes
//   dbg_state  current FSM state (0 IDLE, 1 PRIME, 2 ISSUE, 3 DRAIN)
//
// Handshake: there is no valid/ready pair. `start` is a level sampled on the
// clock edge while IDLE. `stall` is a level that holds every run register on
// any edge where it is high.
module instr_fetch #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int HOLD  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [WIDTH-1:0]         load_data,
  input  logic [$clog2(DEPTH):0]   len,
  input  logic                     start,
  input  logic                     stall,
  output logic [WIDTH-1:0]         next,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               dbg_state
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [WIDTH-1:0] store [DEPTH];
  logic [1:0]       state;
  logic [PW-1:0]    pc_q;
  logic [HW-1:0]    hold_cnt;
  logic [WIDTH-1:0] next_q;
  logic             done_q;
  logic [LW-1:0]    len_q;
`ifdef FETCH_LOOP_EN
  logic             stop_req;
`endif

  logic          hold_last;
  logic          last_entry;
  logic [PW-1:0] pc_inc;

  assign hold_last  = (hold_cnt == HOLD_LAST);
  assign pc_inc     = pc_q + PW'(1);
  assign last_entry = ({1'b0, pc_q} == (len_q - LW'(1)));

  // The store is never reset, so loaded contents survive a reset.
  always_ff @(posedge clk) begin
    if (load_en) store[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc_q     <= '0;
      hold_cnt <= '0;
      next_q   <= '0;
      done_q   <= 1'b0;
      len_q    <= '0;
`ifdef FETCH_LOOP_EN
      stop_req <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            len_q    <= (len > DEPTH_L) ? DEPTH_L : len;
            hold_cnt <= '0;
            pc_q     <= '0;
            next_q   <= '0;
            state    <= PRIME;
`ifdef FETCH_LOOP_EN
            stop_req <= 1'b0;
`endif
          end
        end
        PRIME: begin
          if (!stall) begin
            if (hold_last) begin
              hold_cnt <= '0;
              pc_q     <= '0;
              next_q   <= store[{PW{1'b0}}];
              state    <= ISSUE;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        ISSUE: begin
`ifdef FETCH_LOOP_EN
          // A stop request is remembered even across stalled cycles.
          if (start) stop_req <= 1'b1;
`endif
          if (!stall) begin
            if (hold_last) begin
              hold_cnt <= '0;
              if (last_entry) begin
`ifdef FETCH_LOOP_EN
                // A start arriving on the boundary cycle itself still counts.
                if (stop_req || start) begin
                  state    <= DRAIN;
                  next_q   <= '0;
                  pc_q     <= '0;
                  stop_req <= 1'b0;
                end else begin
                  pc_q   <= '0;
                  next_q <= store[{PW{1'b0}}];
                end
`else
                state  <= DRAIN;
                next_q <= '0;
                pc_q   <= '0;
`endif
              end else begin
                // next only reloads on a boundary, so a write to the entry
                // being presented cannot show up mid-hold.
                pc_q   <= pc_inc;
                next_q <= store[pc_inc];
              end
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        DRAIN: begin
          if (!stall) begin
            if (hold_last) begin
              hold_cnt <= '0;
              state    <= IDLE;
              done_q   <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign next      = next_q;
  assign pc        = pc_q;
  assign busy      = (state == PRIME) || (state == ISSUE);
  assign done      = done_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;
  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int HOLD  = 4;
  localparam int PW    = 3;
  localparam int LW    = 4;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_en;
  logic [PW-1:0]    load_addr;
  logic [WIDTH-1:0] load_data;
  logic [LW-1:0]    len;
  logic             start;
  logic             stall;
  logic [WIDTH-1:0] next;
  logic [PW-1:0]    pc;
  logic             busy;
  logic             done;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  instr_fetch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .len(len), .start(start), .stall(stall),
    .next(next), .pc(pc), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  // A run is a timeline of non-stalled cycles m_t counted from the accepted
  // start: HOLD NOP cycles, then HOLD cycles per entry, then HOLD NOP cycles,
  // then the done cycle. An entry's value is fetched when its slot begins.
  logic [WIDTH-1:0] m_store [DEPTH];
  logic [WIDTH-1:0] m_shown;
  logic [WIDTH-1:0] exp_next = '0;
  int               exp_pc = 0;
  bit               exp_busy = 1'b0;
  bit               exp_done = 1'b0;
  bit               m_active = 1'b0;
  bit               m_stop = 1'b0;
  bit               chk_en = 1'b0;
  int               m_t = 0;
  int               m_len = 0;

  always @(posedge clk) begin
    int k;
    exp_done = 1'b0;
    if (!rst_n) begin
      chk_en = 1'b1;
      m_active = 1'b0;
      exp_next = '0; exp_pc = 0; exp_busy = 1'b0;
    end else if (!m_active) begin
      if (start && len != '0) begin
        m_len = (int'(len) > DEPTH) ? DEPTH : int'(len);
        m_t = 0; m_active = 1'b1; m_stop = 1'b0;
        exp_next = '0; exp_pc = 0; exp_busy = 1'b1;
      end
    end else begin
`ifdef FETCH_LOOP_EN
      if (start && m_t >= HOLD && m_t < HOLD * (m_len + 1)) m_stop = 1'b1;
`endif
      if (!stall) begin
        m_t++;
`ifdef FETCH_LOOP_EN
        if (m_t == HOLD * (m_len + 1) && !m_stop) m_t = HOLD;
`endif
        if (m_t < HOLD) begin
          exp_next = '0; exp_pc = 0; exp_busy = 1'b1;
        end else if (m_t < HOLD * (m_len + 1)) begin
          k = (m_t - HOLD) / HOLD;
          if ((m_t - HOLD) % HOLD == 0) m_shown = m_store[k % DEPTH];
          exp_next = m_shown; exp_pc = k; exp_busy = 1'b1;
        end else if (m_t < HOLD * (m_len + 2)) begin
          exp_next = '0; exp_pc = 0; exp_busy = 1'b0;
        end else begin
          exp_done = 1'b1; m_active = 1'b0;
          exp_next = '0; exp_pc = 0; exp_busy = 1'b0;
        end
      end
    end
    if (load_en) m_store[load_addr] = load_data;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("next", 32'(next), 32'(exp_next));
      check("pc", 32'(pc), exp_pc);
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
    end
  end

  // ---------------- driver tasks ----------------
  logic [WIDTH-1:0] prog [DEPTH];

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic load(input int addr, input logic [WIDTH-1:0] data);
    load_en = 1'b1; load_addr = PW'(addr); load_data = data;
    tick();
    load_en = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) load(i, prog[i]);
  endtask

  task automatic kick(input int l);
    len = LW'(l); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full run of prog[0..n-1] with no stalls; optional start pulse mid-run.
  task automatic run_trace(input int len_in, input int pulse_at);
    int n;
    logic [WIDTH-1:0] e;
    n = (len_in > DEPTH) ? DEPTH : len_in;
    kick(len_in);
    for (int i = 0; i <= HOLD * (n + 2); i++) begin
      @(negedge clk);
      if (i < HOLD || i >= HOLD * (n + 1)) e = '0;
      else e = prog[(i - HOLD) / HOLD];
      check("trace_next", 32'(next), 32'(e));
      check("trace_busy", 32'(busy), 32'(i < HOLD * (n + 1)));
      check("trace_done", 32'(done), 32'(i == HOLD * (n + 2)));
      @(posedge clk); #2;
      start = (i + 1 == pulse_at);
    end
    start = 1'b0;
  endtask

  task automatic run_stall();
    int cnt = 0;
    int bad = 0;
    kick(5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (next == prog[1]) begin
        cnt++;
        if (pc != 3'd1) bad++;
      end
      @(posedge clk); #2;
      stall = (i >= 8 && i <= 10);
    end
    stall = 1'b0;
    check("stall_hold_cycles", cnt, 7);
    check("stall_pc_moved", bad, 0);
  endtask

  task automatic run_reset_mid();
    int dcnt = 0;
    kick(5);
    for (int i = 0; i < 13; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_next", 32'(next), 0);
    check("midrst_pc", 32'(pc), 0);
    check("midrst_busy", 32'(busy), 0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midrst_no_done", dcnt, 0);
    tick();
  endtask

  task automatic run_len0();
    int act = 0;
    kick(0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || done || next != '0) act++;
    end
    check("len0_ignored", act, 0);
    tick();
  endtask

`ifdef FETCH_LOOP_EN
  task automatic run_loop();
    int done_idx = -1;
    logic [WIDTH-1:0] e;
    prog[0] = 4'h3; prog[1] = 4'h5;
    load(0, prog[0]); load(1, prog[1]);
    kick(2);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < HOLD) e = '0;
      else if (i < 20) e = prog[((i - HOLD) / HOLD) % 2];
      else e = '0;
      if (i <= 24) check("loop_next", 32'(next), 32'(e));
      if (done && done_idx < 0) done_idx = i;
      @(posedge clk); #2;
      start = (i + 1 == 14);
    end
    start = 1'b0;
    check("loop_done_at", done_idx, 24);
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    len = '0; start = 1'b0; stall = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_next", 32'(next), 0);
    check("reset_pc", 32'(pc), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    tick();

    prog[0] = 4'hE; prog[1] = 4'hC; prog[2] = 4'hA; prog[3] = 4'h6; prog[4] = 4'h2;
    for (int i = 5; i < DEPTH; i++) prog[i] = WIDTH'($urandom_range(0, 15));
    load_prog();

`ifndef FETCH_LOOP_EN
    run_trace(5, -1);
    run_stall();
    run_reset_mid();
    run_trace(5, -1);
    run_trace(5, 10);
    run_len0();
    prog[0] = 4'h9;
    load(0, prog[0]);
    run_trace(1, -1);
    for (int i = 0; i < DEPTH; i++) prog[i] = WIDTH'(i + 3);
    load_prog();
    run_trace(DEPTH + 3, -1);
`else
    run_loop();
`endif

    for (int i = 0; i < 3000; i++) begin
      load_en   = ($urandom_range(0, 3) == 0);
      load_addr = PW'($urandom_range(0, DEPTH - 1));
      load_data = WIDTH'($urandom_range(0, 15));
      start     = ($urandom_range(0, 19) == 0);
      len       = LW'($urandom_range(0, DEPTH + 3));
      stall     = ($urandom_range(0, 4) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
      tick();
    end
    load_en = 1'b0; start = 1'b0; stall = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 60; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
